pfx_scan_pipe: RTL
==================

PFX_SCAN_PIPE -- requirements
Module: pfx_scan_pipe

Interface
REQ-001 The block SHALL expose these parameters:
  - IWIDTH, 8, element input width in bits.
  - OWIDTH, 16, element output width in bits, OWIDTH >= IWIDTH.
  - V_LEN, 8, elements per beat, a power of two >= 2.
  - SAT, 0, 1 = saturating arithmetic, 0 = wrap modulo 2^OWIDTH.
REQ-002 The block SHALL expose these ports:
  - clk  in  1  single clock; all state changes on posedge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - valid_in  in  1  input beat valid.
  - ready_in  out  1  block accepts a beat this cycle.
  - ivec  in  IWIDTH*V_LEN  elements; element i = ivec[i*IWIDTH +: IWIDTH], unsigned.
  - mode_in  in  1  0 = inclusive scan, 1 = exclusive scan; sampled with the beat.
  - last_in  in  1  beat ends a packet; running carry clears after it.
  - valid_out  out  1  output beat valid.
  - ready_out  in  1  downstream accepts output.
  - ovec  out  OWIDTH*V_LEN  prefix results, same element packing as ivec.
  - last_out  out  1  last_in of the beat, delayed.
  - ovf_out  out  1  any element of this beat saturated or wrapped.

Function
REQ-003 The block SHALL transfer a beat on input when valid_in && ready_in, and on output when valid_out && ready_out.
REQ-004 The pipeline SHALL be L = log2(V_LEN)+1 register stages: log2(V_LEN) Kogge-Stone stages, then one carry-add stage.
REQ-005 Pipeline advance enable SHALL be en = !valid_out || ready_out; ready_in SHALL equal en. ready_in depends combinationally on ready_out and valid_out only, never on valid_in.
REQ-006 With ready_out held high, a beat accepted in cycle t SHALL appear on valid_out in cycle t+L; throughput SHALL be one beat per cycle.
REQ-007 When en=0, every stage register, including per-stage valid, mode and last, SHALL hold its value; no beat SHALL be lost or duplicated.
REQ-008 The local sum s[i] of elements 0..i within the beat SHALL be computed at OWIDTH bits, with saturation or wrap per SAT at every addition.
REQ-009 The output SHALL be ovec[i] = carry + s[i] in inclusive mode, and ovec[i] = carry + s[i-1], with ovec[0] = carry, in exclusive mode.
REQ-010 The carry register SHALL be OWIDTH bits and SHALL update only when a beat leaves the final stage (en && final-stage valid).
  - Update value: carry + s[V_LEN-1] (the beat total), in both modes.
  - It SHALL become 0 instead when that beat has last=1.
REQ-011 ovf_out SHALL be 1 if any addition contributing to that beat's ovec or to the carry update exceeded 2^OWIDTH-1. With SAT=1 such results clamp to 2^OWIDTH-1; with SAT=0 they wrap.
REQ-012 Mode, last and ovf SHALL travel with their beat through all stages.
REQ-013 A bubble (valid_in=0 while ready_in=1) SHALL propagate as invalid and SHALL NOT alter the carry.

Reset
REQ-014 While rst_n=0, all stage valid bits, the carry, valid_out, last_out and ovf_out SHALL be 0. ovec is don't-care while valid_out=0.
REQ-015 Reset asserted mid-packet SHALL discard all in-flight beats and clear the carry. The first beat after reset release SHALL start a new packet.
REQ-016 Data registers SHALL NOT require reset; only control and carry state is reset.

Structure
REQ-017 A shared package pfx_pkg SHALL hold:
  - the mode encoding constants (MODE_INCL=0, MODE_EXCL=1);
  - a clog2 helper function;
  - a saturating/wrapping add function parameterised by SAT.
REQ-018 One sub-module pfx_stage SHALL implement a single Kogge-Stone level (distance parameter D), instantiated log2(V_LEN) times via generate; the carry-add stage stays in pfx_scan_pipe.

Verification (IWIDTH=8, OWIDTH=16, V_LEN=8 unless noted)
REQ-019 Inclusive scan: ivec=1..8, mode=0, last=1, ready_out=1 -> after 4 cycles ovec=1,3,6,10,15,21,28,36, last_out=1, ovf_out=0.
REQ-020 Exclusive scan: same ivec, mode=1 -> ovec=0,1,3,6,10,15,21,28.
REQ-021 Two-beat packet, all elements 1:
  - beat A last=0 -> ovec=1..8;
  - beat B last=1 -> ovec=9..16;
  - beat C afterwards, all 1 -> ovec=1..8 (carry cleared).
REQ-022 Backpressure: 6 back-to-back beats, ready_out low for 5 cycles mid-stream -> ready_in low during the stall, all 6 outputs emitted in order with correct values, none dropped or repeated.
REQ-023 Overflow, OWIDTH=8, all elements 255, inclusive:
  - SAT=1 -> ovec all 255, ovf_out=1;
  - SAT=0 -> ovec=255,254,253,252,251,250,249,248, ovf_out=1.
REQ-024 Reset mid-packet: beat last=0 (all 1s) in flight, pulse rst_n low 1 cycle -> valid_out=0 during reset, beat lost; next beat of all 1s -> ovec=1..8.

Source files
------------

// File: rtl/pfx_pkg.sv
// Shared definitions for the prefix-scan pipeline.
//   MODE_INCL / MODE_EXCL : scan mode encoding carried with each beat.
//   clog2()               : ceiling log2 for elaboration-time sizing.
//   sat_add()             : unsigned add at a run-time width w (w < ADD_MAXW),
//                           returning {overflow, result}; result clamps to
//                           2^w-1 when sat is set, otherwise wraps modulo 2^w.
package pfx_pkg;

   localparam logic MODE_INCL = 1'b0;
   localparam logic MODE_EXCL = 1'b1;

   localparam int ADD_MAXW = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Operands must already fit in w bits; the overflow flag is the carry
   // out of bit w-1.
   function automatic logic [ADD_MAXW:0] sat_add(input logic [ADD_MAXW-1:0] a,
                                                 input logic [ADD_MAXW-1:0] b,
                                                 input int w,
                                                 input bit sat);
      logic [ADD_MAXW:0] full;
      logic [ADD_MAXW:0] maxv;
      logic [ADD_MAXW:0] res;
      logic              ovf;
      full = {1'b0, a} + {1'b0, b};
      maxv = ({{ADD_MAXW{1'b0}}, 1'b1} << w) - 1'b1;
      ovf  = (full > maxv);
      if (!ovf)     res = full;
      else if (sat) res = maxv;
      else          res = full & maxv;
      return {ovf, res[ADD_MAXW-1:0]};
   endfunction

endpackage

// File: rtl/pfx_stage.sv
// One Kogge-Stone level of the in-beat prefix sum.
//   Element i (i >= D) becomes x[i] + x[i-D]; lower elements pass through.
//   Ports: clk, rst_n (async, active-low), en (pipeline advance),
//          vld/mode/last/ovf sideband in/out travelling with the beat,
//          vec_in/vec_out packed OWIDTH-bit elements.
//   Sideband state is reset; the element data register is not.
module pfx_stage
   import pfx_pkg::*;
#(
   parameter int OWIDTH = 16,
   parameter int V_LEN  = 8,
   parameter int SAT    = 0,
   parameter int D      = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      vld_in,
   input  logic                      mode_in,
   input  logic                      last_in,
   input  logic                      ovf_in,
   input  logic [OWIDTH*V_LEN-1:0]   vec_in,
   output logic                      vld_out,
   output logic                      mode_out,
   output logic                      last_out,
   output logic                      ovf_out,
   output logic [OWIDTH*V_LEN-1:0]   vec_out
);

   logic                    vld_d,  vld_q;
   logic                    mode_d, mode_q;
   logic                    last_d, last_q;
   logic                    ovf_d,  ovf_q;
   logic [OWIDTH*V_LEN-1:0] vec_d,  vec_q;

   always_comb begin
      logic [ADD_MAXW:0] r;
      int                j;
      vld_d  = vld_q;
      mode_d = mode_q;
      last_d = last_q;
      ovf_d  = ovf_q;
      vec_d  = vec_q;
      r      = '0;
      j      = 0;
      if (en) begin
         vld_d  = vld_in;
         mode_d = mode_in;
         last_d = last_in;
         ovf_d  = ovf_in;
         for (int i = 0; i < V_LEN; i++) begin
            if (i >= D) begin
               j = i - D;
               r = sat_add(ADD_MAXW'(vec_in[i*OWIDTH +: OWIDTH]),
                           ADD_MAXW'(vec_in[j*OWIDTH +: OWIDTH]),
                           OWIDTH, SAT != 0);
               vec_d[i*OWIDTH +: OWIDTH] = r[OWIDTH-1:0];
               ovf_d = ovf_d | r[ADD_MAXW];
            end else begin
               vec_d[i*OWIDTH +: OWIDTH] = vec_in[i*OWIDTH +: OWIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         mode_q <= 1'b0;
         last_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         mode_q <= mode_d;
         last_q <= last_d;
         ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      vec_q <= vec_d;
   end

   assign vld_out  = vld_q;
   assign mode_out = mode_q;
   assign last_out = last_q;
   assign ovf_out  = ovf_q;
   assign vec_out  = vec_q;

endmodule

// File: rtl/pfx_scan_pipe.sv
// Pipelined packet prefix scan over V_LEN unsigned elements per beat.
//   log2(V_LEN) Kogge-Stone levels build the in-beat prefix sums, then a
//   carry-add stage folds in the running packet carry (inclusive or
//   exclusive per beat) and advances the carry by the beat total.
//   Ports: clk, rst_n (async, active-low);
//          valid_in/ready_in, ivec, mode_in, last_in : input beat;
//          valid_out/ready_out, ovec, last_out, ovf_out : output beat.
//   The whole pipe stalls together: ready_in = !valid_out || ready_out.
module pfx_scan_pipe
   import pfx_pkg::*;
#(
   parameter int IWIDTH = 8,
   parameter int OWIDTH = 16,
   parameter int V_LEN  = 8,
   parameter int SAT    = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   output logic                     ready_in,
   input  logic [IWIDTH*V_LEN-1:0]  ivec,
   input  logic                     mode_in,
   input  logic                     last_in,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [OWIDTH*V_LEN-1:0]  ovec,
   output logic                     last_out,
   output logic                     ovf_out
);

   localparam int NLVL = clog2(V_LEN);

   logic                    en;
   logic [OWIDTH*V_LEN-1:0] ks_vec  [NLVL+1];
   logic                    ks_vld  [NLVL+1];
   logic                    ks_mode [NLVL+1];
   logic                    ks_last [NLVL+1];
   logic                    ks_ovf  [NLVL+1];

   assign en       = !valid_out || ready_out;
   assign ready_in = en;

   // Level 0: zero-extend the input elements to the output width.
   for (genvar i = 0; i < V_LEN; i++) begin : g_ext
      assign ks_vec[0][i*OWIDTH +: OWIDTH] = OWIDTH'(ivec[i*IWIDTH +: IWIDTH]);
   end
   assign ks_vld[0]  = valid_in;
   assign ks_mode[0] = mode_in;
   assign ks_last[0] = last_in;
   assign ks_ovf[0]  = 1'b0;

   for (genvar k = 0; k < NLVL; k++) begin : g_lvl
      pfx_stage #(
         .OWIDTH (OWIDTH),
         .V_LEN  (V_LEN),
         .SAT    (SAT),
         .D      (1 << k)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en),
         .vld_in   (ks_vld[k]),
         .mode_in  (ks_mode[k]),
         .last_in  (ks_last[k]),
         .ovf_in   (ks_ovf[k]),
         .vec_in   (ks_vec[k]),
         .vld_out  (ks_vld[k+1]),
         .mode_out (ks_mode[k+1]),
         .last_out (ks_last[k+1]),
         .ovf_out  (ks_ovf[k+1]),
         .vec_out  (ks_vec[k+1])
      );
   end

   // Carry-add stage.
   logic                    vo_d,    vo_q;
   logic                    last_d,  last_q;
   logic                    ovf_d,   ovf_q;
   logic [OWIDTH*V_LEN-1:0] ovec_d,  ovec_q;
   logic [OWIDTH-1:0]       carry_d, carry_q;
   logic [ADD_MAXW:0]       add_r [V_LEN];

   // add_r[i] = carry + s[i]; the exclusive result for element i is
   // add_r[i-1], and add_r[V_LEN-1] is also the next carry.
   always_comb begin
      for (int i = 0; i < V_LEN; i++) begin
         add_r[i] = sat_add(ADD_MAXW'(carry_q),
                            ADD_MAXW'(ks_vec[NLVL][i*OWIDTH +: OWIDTH]),
                            OWIDTH, SAT != 0);
      end
   end

   always_comb begin
      logic any_ovf;
      vo_d    = vo_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      ovec_d  = ovec_q;
      carry_d = carry_q;
      any_ovf = 1'b0;
      for (int i = 0; i < V_LEN; i++) begin
         any_ovf = any_ovf | add_r[i][ADD_MAXW];
      end
      if (en) begin
         vo_d   = ks_vld[NLVL];
         last_d = ks_last[NLVL];
         ovf_d  = ks_ovf[NLVL] | any_ovf;
         for (int i = 0; i < V_LEN; i++) begin
            if (ks_mode[NLVL] == MODE_EXCL) begin
               if (i == 0) ovec_d[i*OWIDTH +: OWIDTH] = carry_q;
               else        ovec_d[i*OWIDTH +: OWIDTH] = add_r[i-1][OWIDTH-1:0];
            end else begin
               ovec_d[i*OWIDTH +: OWIDTH] = add_r[i][OWIDTH-1:0];
            end
         end
         // The carry advances as the beat is captured here, so a beat
         // following back-to-back already sees the updated value.
         if (ks_vld[NLVL]) begin
            carry_d = ks_last[NLVL] ? '0 : add_r[V_LEN-1][OWIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vo_q    <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
         carry_q <= '0;
      end else begin
         vo_q    <= vo_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         carry_q <= carry_d;
      end
   end

   always_ff @(posedge clk) begin
      ovec_q <= ovec_d;
   end

   assign valid_out = vo_q;
   assign last_out  = last_q;
   assign ovf_out   = ovf_q;
   assign ovec      = ovec_q;

endmodule
